// File: rtl/mux_sync_nx1_pkg.sv
// Shared defaults and FSM state type for the
// carrier-synchronous N:1 channel mux.
package PKG_pwm;

  localparam int N_CH_DEF = 8;
  localparam int W_DEF    = 1;
  localparam int DT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

endpackage

// File: rtl/mux_sync_nx1_dt_counter.sv
// Blanking down-counter: load at the carrier
// boundary, count down, flag the final cycle.
module dt_counter
  import PKG_pwm::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            dec,
  input  logic [DT_W-1:0] load_val,
  output logic            last
);

  logic [DT_W-1:0] cnt_q;
  logic [DT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == DT_W'(1));

endmodule

// File: rtl/mux_sync_nx1.sv
// Registered N:1 channel mux whose selection only
// changes at a carrier boundary, with optional blanking.
module mux_sync_nx1
  import PKG_pwm::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int W    = W_DEF,
  parameter int DT_W = DT_W_DEF,
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [SEL_W-1:0]  sel_req,
  input  logic              sel_valid,
  output logic              sel_ready,
  input  logic              sync_i,
  input  logic [DT_W-1:0]   dt_cycles,
  input  logic [W-1:0]      idle_val,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  sel_cur,
  output logic              busy,
  output logic              sel_err
);

  localparam logic [SEL_W:0] N_CH_L = (SEL_W+1)'(N_CH);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_cur_q, sel_cur_d;
  logic [SEL_W-1:0]  sel_nxt_q, sel_nxt_d;
  logic [W-1:0]      out_q, out_d;
  logic              err_q, err_d;

  logic              accept;
  logic              req_bad;
  logic              cnt_load;
  logic              cnt_last;
  logic              use_idle;
  logic [SEL_W-1:0]  mux_sel;
  logic [W-1:0]      mux_out;

  assign accept  = sel_valid && (state_q == ST_RUN);
  assign req_bad = ({1'b0, sel_req} >= N_CH_L);

  always_comb begin
    state_d   = state_q;
    sel_cur_d = sel_cur_q;
    sel_nxt_d = sel_nxt_q;
    err_d     = 1'b0;
    cnt_load  = 1'b0;
    use_idle  = 1'b0;
    mux_sel   = sel_cur_q;
    unique case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else if (sel_req != sel_cur_q) begin
            sel_nxt_d = sel_req;
            state_d   = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (sync_i) begin
          if (dt_cycles == '0) begin
            sel_cur_d = sel_nxt_q;
            state_d   = ST_RUN;
          end else begin
            cnt_load = 1'b1;
            use_idle = 1'b1;
            state_d  = ST_BLANK;
          end
        end
      end
      ST_BLANK: begin
        // last blank cycle: the register picks up the new channel
        if (cnt_last) begin
          sel_cur_d = sel_nxt_q;
          mux_sel   = sel_nxt_q;
          state_d   = ST_RUN;
        end else begin
          use_idle = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    mux_out = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (mux_sel == SEL_W'(k)) begin
        mux_out = in_data[k*W +: W];
      end
    end
  end

  assign out_d = use_idle ? idle_val : mux_out;

  dt_counter #(
    .DT_W (DT_W)
  ) u_dt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (state_q == ST_BLANK),
    .load_val (dt_cycles),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      sel_cur_q <= '0;
      sel_nxt_q <= '0;
      out_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_cur_q <= sel_cur_d;
      sel_nxt_q <= sel_nxt_d;
      out_q     <= out_d;
      err_q     <= err_d;
    end
  end

  assign sel_ready = (state_q == ST_RUN);
  assign busy      = (state_q != ST_RUN);
  assign out_data  = out_q;
  assign sel_cur   = sel_cur_q;
  assign sel_err   = err_q;

endmodule

// File: tb/tb_mux_sync_nx1.sv
// Directed bench for mux_sync_nx1 (6 channels, 4 bits).
module tb_mux_sync_nx1;

  localparam int N_CH  = 6;
  localparam int W     = 4;
  localparam int DT_W  = 8;
  localparam int SEL_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH*W-1:0] in_data;
  logic [SEL_W-1:0]  sel_req;
  logic              sel_valid;
  logic              sel_ready;
  logic              sync_i;
  logic [DT_W-1:0]   dt_cycles;
  logic [W-1:0]      idle_val;
  logic [W-1:0]      out_data;
  logic [SEL_W-1:0]  sel_cur;
  logic              busy;
  logic              sel_err;

  logic [W-1:0] ch [N_CH];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  always_comb begin
    in_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      in_data[k*W +: W] = ch[k];
    end
  end

  mux_sync_nx1 #(
    .N_CH (N_CH),
    .W    (W),
    .DT_W (DT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .sel_req   (sel_req),
    .sel_valid (sel_valid),
    .sel_ready (sel_ready),
    .sync_i    (sync_i),
    .dt_cycles (dt_cycles),
    .idle_val  (idle_val),
    .out_data  (out_data),
    .sel_cur   (sel_cur),
    .busy      (busy),
    .sel_err   (sel_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ch();
    for (int k = 0; k < N_CH; k++) ch[k] = '0;
  endtask

  initial begin
    rst       = 1'b1;
    sel_req   = '0;
    sel_valid = 1'b0;
    sync_i    = 1'b0;
    dt_cycles = '0;
    idle_val  = '0;
    clr_ch();
    ch[0] = 4'hA;
    tick();
    tick();
    chk("rst_out",   32'(out_data), 32'h0);
    chk("rst_cur",   32'(sel_cur), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_err",   32'(sel_err), 32'h0);
    chk("rst_ready", 32'(sel_ready), 32'h1);
    rst = 1'b0;
    tick();
    chk("first_out", 32'(out_data), 32'hA);

    // channel 3 with no blanking
    clr_ch();
    ch[3] = 4'h1;
    sel_req = 3'd3;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    chk("t1_busy",  32'(busy), 32'h1);
    chk("t1_rdy",   32'(sel_ready), 32'h0);
    chk("t1_cur0",  32'(sel_cur), 32'h0);
    sync_i = 1'b1;
    tick();
    sync_i = 1'b0;
    chk("t1_cur3",  32'(sel_cur), 32'h3);
    chk("t1_nbusy", 32'(busy), 32'h0);
    chk("t1_old",   32'(out_data), 32'h0);
    tick();
    chk("t1_new",   32'(out_data), 32'h1);

    // channel 5 with 4 blanking cycles
    ch[3] = 4'h2;
    ch[5] = 4'h7;
    idle_val = 4'h0;
    sel_req = 3'd5;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    chk("t2_busy_acc", 32'(busy), 32'h1);
    tick();
    chk("t2_pend_out", 32'(out_data), 32'h2);
    sync_i = 1'b1;
    dt_cycles = 8'd4;
    tick();
    sync_i = 1'b0;
    dt_cycles = 8'd9;
    chk("t2_blank0", 32'(out_data), 32'h0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t2_blank", 32'(out_data), 32'h0);
      chk("t2_bbusy", 32'(busy), 32'h1);
      chk("t2_bcur",  32'(sel_cur), 32'h3);
    end
    tick();
    chk("t2_new",   32'(out_data), 32'h7);
    chk("t2_cur5",  32'(sel_cur), 32'h5);
    chk("t2_nbusy", 32'(busy), 32'h0);

    // out-of-range request
    sel_req = 3'd7;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    chk("t3_err",   32'(sel_err), 32'h1);
    chk("t3_rdy",   32'(sel_ready), 32'h1);
    chk("t3_cur",   32'(sel_cur), 32'h5);
    chk("t3_busy",  32'(busy), 32'h0);
    tick();
    chk("t3_err_off", 32'(sel_err), 32'h0);
    sel_req = 3'd6;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    chk("t3_err6",  32'(sel_err), 32'h1);

    // request equal to current channel
    sel_req = 3'd5;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    chk("t3_same_busy", 32'(busy), 32'h0);
    chk("t3_same_err",  32'(sel_err), 32'h0);

    // request with sync in same cycle
    ch[2] = 4'h9;
    dt_cycles = 8'd0;
    sel_req = 3'd2;
    sel_valid = 1'b1;
    sync_i = 1'b1;
    tick();
    sel_valid = 1'b0;
    sync_i = 1'b0;
    chk("t4_busy", 32'(busy), 32'h1);
    chk("t4_cur5", 32'(sel_cur), 32'h5);
    tick();
    chk("t4_wait", 32'(sel_cur), 32'h5);
    chk("t4_out7", 32'(out_data), 32'h7);
    sync_i = 1'b1;
    tick();
    sync_i = 1'b0;
    chk("t4_cur2", 32'(sel_cur), 32'h2);
    tick();
    chk("t4_out9", 32'(out_data), 32'h9);
    sync_i = 1'b1;
    tick();
    sync_i = 1'b0;
    chk("t4_run_sync", 32'(busy), 32'h0);

    // request during PEND is ignored
    idle_val = 4'h5;
    sel_req = 3'd3;
    sel_valid = 1'b1;
    tick();
    sel_req = 3'd4;
    tick();
    sel_valid = 1'b0;
    chk("t5_busy", 32'(busy), 32'h1);
    sync_i = 1'b1;
    dt_cycles = 8'd2;
    tick();
    sync_i = 1'b0;
    chk("t5_idle0", 32'(out_data), 32'h5);
    tick();
    chk("t5_idle1", 32'(out_data), 32'h5);
    tick();
    chk("t5_new", 32'(out_data), 32'h2);
    chk("t5_cur3", 32'(sel_cur), 32'h3);

    // reset in 2nd blanking cycle
    ch[0] = 4'h3;
    ch[1] = 4'hC;
    sel_req = 3'd1;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    sync_i = 1'b1;
    dt_cycles = 8'd5;
    tick();
    sync_i = 1'b0;
    tick();
    chk("t6_blank", 32'(out_data), 32'h5);
    rst = 1'b1;
    #1;
    chk("t6_rout",  32'(out_data), 32'h0);
    chk("t6_rcur",  32'(sel_cur), 32'h0);
    chk("t6_rbusy", 32'(busy), 32'h0);
    tick();
    rst = 1'b0;
    chk("t6_rdy", 32'(sel_ready), 32'h1);
    tick();
    chk("t6_out0", 32'(out_data), 32'h3);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_cur0", 32'(sel_cur), 32'h0);
    end
    chk("t6_busy", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_sync_nx1.md
MUX_SYNC_NX1 -- requirements
Module: mux_sync_nx1

Interface
REQ-001 The block SHALL have parameter N_CH, default 8, giving the number of input channels (2..64).
REQ-002 The block SHALL have parameter W, default 1, giving the bit width of each channel.
REQ-003 The block SHALL have parameter DT_W, default 8, giving the width of the blanking-count input.
REQ-004 The block SHALL derive constant SEL_W = clog2(N_CH), with a minimum of 1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port in_data, input, N_CH*W bits: channel k occupies bits [k*W +: W].
REQ-008 The block SHALL have port sel_req, input, SEL_W bits: the requested channel index.
REQ-009 The block SHALL have port sel_valid, input, 1 bit: sel_req is valid in this cycle.
REQ-010 The block SHALL have port sel_ready, output, 1 bit: the block can accept a request.
REQ-011 The block SHALL have port sync_i, input, 1 bit: a one-cycle carrier-boundary strobe (PWM period start).
REQ-012 The block SHALL have port dt_cycles, input, DT_W bits: the blanking length in clk cycles.
REQ-013 The block SHALL have port idle_val, input, W bits: the output value driven during blanking.
REQ-014 The block SHALL have port out_data, output, W bits: the registered selected channel.
REQ-015 The block SHALL have port sel_cur, output, SEL_W bits: the channel currently routed.
REQ-016 The block SHALL have port busy, output, 1 bit: high while in PEND or BLANK.
REQ-017 The block SHALL have port sel_err, output, 1 bit: a one-cycle pulse on a rejected request.

Function
REQ-018 The FSM SHALL have the states RUN, PEND and BLANK.
REQ-019 In RUN, out_data SHALL equal in_data channel sel_cur sampled one cycle earlier (latency 1).
REQ-020 sel_ready SHALL be 1 only in RUN, and a request SHALL be accepted when sel_valid and sel_ready are both high.
REQ-021 An accepted sel_req >= N_CH SHALL be discarded, pulse sel_err for 1 cycle, and cause no state change.
REQ-022 An accepted sel_req equal to sel_cur SHALL be acknowledged and cause no state change and no blanking.
REQ-023 Any other accepted request SHALL latch sel_req into sel_nxt and move the FSM RUN->PEND.
REQ-024 A sync_i in the same cycle as acceptance SHALL be ignored, so the switch waits for the next sync_i.
REQ-025 On sync_i in PEND with dt_cycles == 0, the FSM SHALL set sel_cur <= sel_nxt and go PEND->RUN, and out_data SHALL take the new channel one cycle later.
REQ-026 On sync_i in PEND with dt_cycles > 0, the FSM SHALL load the counter with dt_cycles and go PEND->BLANK.
REQ-027 In BLANK, out_data SHALL equal idle_val for exactly dt_cycles cycles, starting the cycle after the sync_i.
REQ-028 dt_cycles SHALL be sampled only at sync_i, so a change during BLANK has no effect.
REQ-029 When the counter reaches 1 in BLANK, the FSM SHALL set sel_cur <= sel_nxt and go BLANK->RUN, and out_data SHALL show the new channel on the following cycle.
REQ-030 sync_i SHALL be ignored in BLANK and in RUN.
REQ-031 sel_valid while sel_ready = 0 SHALL be ignored (not queued).
REQ-032 sel_cur SHALL change only on the PEND->RUN or BLANK->RUN transition.

Reset
REQ-033 While rst is high, the block SHALL force: state = RUN, sel_cur = 0, sel_nxt = 0, counter = 0, out_data = 0, sel_err = 0, busy = 0.
REQ-034 Reset asserted mid-PEND or mid-BLANK SHALL abandon the pending switch, and sel_cur SHALL be 0 after release.
REQ-035 The first out_data after reset release SHALL be channel 0 on the first rising edge.

Structure
REQ-036 The FSM state enum type and the default values for N_CH, W and DT_W SHALL reside in the shared package PKG_pwm.
REQ-037 The blanking counter (load, decrement, last flag) SHALL be a sub-module named dt_counter.
REQ-038 The output register SHALL be one W-bit flop stage, fed by a combinational N_CH:1 select or by idle_val.

Verification
REQ-039 Hold channel 3 = 1 and all others = 0, with sel_cur = 0 after reset -> request 3, sync_i, dt_cycles = 0 -> out_data = 1 two cycles after sync_i and sel_cur = 3.
REQ-040 Request 5 with dt_cycles = 4 and idle_val = 0 -> out_data = 0 for exactly 4 cycles after sync_i, then channel 5, and busy high from acceptance until the RUN return.
REQ-041 With N_CH = 6, request 7 -> sel_err pulses for 1 cycle, sel_ready stays 1, and sel_cur is unchanged.
REQ-042 Request 2 together with sync_i in the same cycle -> no switch until the next sync_i, with sel_cur = 2 after it.
REQ-043 Assert rst in the 2nd BLANK cycle -> out_data = 0, sel_cur = 0 and state RUN, with sel_ready = 1 after release.
REQ-044 Assert sel_valid with sel_req = 4 during PEND -> it is ignored, and the original sel_nxt is applied at sync_i.
